regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-back arbiter and scoreboard for the 16-entry register unit. It shares the register unit's single write port (a3/wd3/we3) between the ALU result path and the memory-load path. It tracks which destination registers have a write in flight and raises a read hazard to the decode stage. Writes addressed to register 15 are redirected to the PC-update outputs, because reads of r15 are served from the PC rather than from the array.

## Interface
- DATA_W, 16, write-back data width
- ADDR_W, 4, register address width (16 registers; address 15 = PC)
- STARVE_MAX, 3, consecutive ALU losses before the ALU is forced a grant (1..7)

- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- alu_valid  in  1  ALU write-back request
- alu_addr  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- alu_ready  out  1  ALU request granted this cycle (combinational)
- mem_valid  in  1  load write-back request
- mem_addr  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load data
- mem_ready  out  1  load request granted this cycle (combinational)
- issue_valid  in  1  decode reserves a destination register
- issue_addr  in  ADDR_W  reserved destination
- rs1_addr, rs2_addr  in  ADDR_W each  source registers of the instruction in decode
- hazard  out  1  a source register has a pending write (combinational)
- we3  out  1  register-unit write enable (registered)
- a3  out  ADDR_W  register-unit write address (registered)
- wd3  out  DATA_W  register-unit write data (registered)
- pc_we  out  1  PC write enable for address-15 write-backs (registered)
- pc_wd  out  DATA_W  PC write data (registered)

## Operation
- Transfer occurs when valid && ready. At most one ready is high per cycle.
- Arbitration:
  - mem has fixed priority over alu.
  - An alu_valid cycle that loses to mem increments starve_cnt (3 bits).
  - When starve_cnt == STARVE_MAX and both are valid, alu wins.
  - starve_cnt clears on any ALU grant and on any cycle with alu_valid low.
- Write stage, one register, loaded from the winner on every cycle:
  - addr != 15: we3=1, a3/wd3 take the winner's addr/data, pc_we=0.
  - addr == 15: pc_we=1, pc_wd=data, we3=0.
  - No grant: we3=0, pc_we=0; a3/wd3/pc_wd hold their previous values.
- Scoreboard: busy[15:0], where busy[15] is always 0.
  - Set: issue_valid && issue_addr != 15 sets busy[issue_addr] on the next edge.
  - Clear: a granted write-back to address n clears busy[n] on the next edge, i.e. the same edge that asserts we3.
  - Set and clear of the same address in the same cycle: set wins (a new reservation).
- hazard = busy[rs1_addr] | busy[rs2_addr]. It is combinational from the current busy state only; the same-cycle grant is not bypassed.
- A write-back to a register that is not busy is legal: it is written and busy is unchanged.

## Timing
- Grant to we3/pc_we: 1 cycle. The register unit commits on the following edge, so total latency is 2 edges.
- Issue to hazard visible: 1 cycle. Grant to hazard release: 1 cycle.
- Throughput: 1 write-back per cycle. A losing requester must hold valid, addr and data stable until it receives ready.
- Reset, synchronous, active-high:
  - we3=0, pc_we=0, a3=0, wd3=0, pc_wd=0, busy=0, starve_cnt=0.
  - alu_ready and mem_ready are forced 0 while reset is high.
  - A write-back held in the write stage when reset asserts is discarded, not committed.

## Structure
- Shared package regfile_pkg:
  - DATA_W and ADDR_W localparams.
  - PC_REG = 4'hF.
  - wb_req_t struct {valid, addr, data}, used for both requester ports internally.
- Natural sub-module: wb_scoreboard (busy vector, set/clear priority, hazard lookup). The arbiter and write stage stay in the top module.

## Test plan
- Single ALU write: alu_valid, addr=3, data=16'h1234 → alu_ready the same cycle; next cycle we3=1, a3=3, wd3=1234; pc_we=0.
- Contention: both valid continuously with STARVE_MAX=3 → grant sequence mem,mem,mem,alu,mem,mem,mem,alu…; ready is never high on both at once.
- PC redirect: mem write to addr 15, data=16'h00F0 → next cycle pc_we=1, pc_wd=00F0, we3=0; busy unchanged.
- Scoreboard: issue addr=5, then rs1=5 → hazard=1 from the next cycle. An ALU write to 5 granted at cycle t → hazard=0 at t+1. Issue to 5 and grant to 5 in the same cycle → busy[5] stays 1.
- Reset mid-operation: grant at t, reset high at t+1 → we3=0 at t+1 and t+2, busy all 0, readys 0 during reset.
- Reset values: after reset with no stimulus, all outputs are 0 and hazard=0 for every rs1/rs2 combination.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-unit write-back path.
// Address 15 is the PC, so writes to it never reach the register array.
package regfile_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] PC_REG = 4'hF;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_ALU,
    GNT_MEM
  } grant_t;

  function automatic logic is_pc(input logic [ADDR_W-1:0] addr);
    return addr == PC_REG;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Valid/ready handshake bundle for the two write-back requesters (ALU and load).
// The requesters use the master modport; the arbiter uses the slave modport.
interface regfile_wb_arbiter_if;
  import regfile_pkg::*;

  logic              alu_valid;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;

  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;

  modport master (
    output alu_valid, alu_addr, alu_data,
    output mem_valid, mem_addr, mem_data,
    input  alu_ready, mem_ready
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  mem_valid, mem_addr, mem_data,
    output alu_ready, mem_ready
  );

endinterface

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, with r15 never busy.
// A reservation and a write-back to the same register on the same edge leave it busy.
module wb_scoreboard
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              set_valid,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_valid,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic              hazard
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_valid && !is_pc(set_addr)) begin
      set_mask[set_addr] = 1'b1;
    end
    if (clr_valid) begin
      clr_mask[clr_addr] = 1'b1;
    end
    busy_nxt         = (busy & ~clr_mask) | set_mask;
    busy_nxt[PC_REG] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // The same-cycle grant is deliberately not bypassed into the hazard.
  assign hazard = busy[rs1_addr] | busy[rs2_addr];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register unit's single write port between the ALU and load paths,
// redirects r15 writes to the PC, and reports read hazards via the scoreboard.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int STARVE_MAX = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_wb_arbiter_if.slave  wb,
  input  logic                 issue_valid,
  input  logic [ADDR_W-1:0]    issue_addr,
  input  logic [ADDR_W-1:0]    rs1_addr,
  input  logic [ADDR_W-1:0]    rs2_addr,
  output logic                 hazard,
  output logic                 we3,
  output logic [ADDR_W-1:0]    a3,
  output logic [DATA_W-1:0]    wd3,
  output logic                 pc_we,
  output logic [DATA_W-1:0]    pc_wd
);

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  wb_req_t     alu_req;
  wb_req_t     mem_req;
  wb_req_t     win;
  grant_t      grant;
  logic [2:0]  starve_cnt;
  logic [2:0]  starve_nxt;
  logic        alu_starved;

  logic              we3_q;
  logic              pc_we_q;
  logic [ADDR_W-1:0] a3_q;
  logic [DATA_W-1:0] wd3_q;
  logic [DATA_W-1:0] pc_wd_q;

  assign alu_req = '{valid: wb.alu_valid, addr: wb.alu_addr, data: wb.alu_data};
  assign mem_req = '{valid: wb.mem_valid, addr: wb.mem_addr, data: wb.mem_data};

  assign alu_starved = (starve_cnt == STARVE_LIM);

  // Loads win by default; an ALU that has lost STARVE_MAX times in a row wins once.
  always_comb begin
    grant      = GNT_NONE;
    win        = '0;
    starve_nxt = '0;
    if (!reset) begin
      if (alu_req.valid && (!mem_req.valid || alu_starved)) begin
        grant = GNT_ALU;
        win   = alu_req;
      end else if (mem_req.valid) begin
        grant = GNT_MEM;
        win   = mem_req;
        if (alu_req.valid) begin
          starve_nxt = starve_cnt + 3'd1;
        end
      end
    end
  end

  assign wb.alu_ready = (grant == GNT_ALU);
  assign wb.mem_ready = (grant == GNT_MEM);

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_nxt;
    end
  end

  // Write stage: a3/wd3/pc_wd keep their last values on idle cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      we3_q   <= 1'b0;
      pc_we_q <= 1'b0;
      a3_q    <= '0;
      wd3_q   <= '0;
      pc_wd_q <= '0;
    end else begin
      we3_q   <= 1'b0;
      pc_we_q <= 1'b0;
      if (win.valid) begin
        if (is_pc(win.addr)) begin
          pc_we_q <= 1'b1;
          pc_wd_q <= win.data;
        end else begin
          we3_q <= 1'b1;
          a3_q  <= win.addr;
          wd3_q <= win.data;
        end
      end
    end
  end

  // A write held in the stage when reset rises must not commit on the next edge.
  assign we3   = we3_q & ~reset;
  assign pc_we = pc_we_q & ~reset;
  assign a3    = a3_q;
  assign wd3   = wd3_q;
  assign pc_wd = pc_wd_q;

  wb_scoreboard u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .set_valid (issue_valid),
    .set_addr  (issue_addr),
    .clr_valid (win.valid),
    .clr_addr  (win.addr),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .hazard    (hazard)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter, checked against a
// behavioural model of the arbitration, write stage and pending-write set.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int STARVE_MAX = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic [3:0]  issue_addr;
  logic [3:0]  rs1_addr;
  logic [3:0]  rs2_addr;
  logic        hazard;
  logic        we3;
  logic [3:0]  a3;
  logic [15:0] wd3;
  logic        pc_we;
  logic [15:0] pc_wd;

  regfile_wb_arbiter_if bus();

  regfile_wb_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk         (clk),
    .reset       (reset),
    .wb          (bus.slave),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .hazard      (hazard),
    .we3         (we3),
    .a3          (a3),
    .wd3         (wd3),
    .pc_we       (pc_we),
    .pc_wd       (pc_wd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit [15:0] busy_m;
  int        losses;
  bit        m_we3, m_pc_we;
  bit [3:0]  m_a3;
  bit [15:0] m_wd3, m_pc_wd;
  bit        exp_alu_rdy, exp_mem_rdy;

  // Random stimulus state
  bit        alu_hold, mem_hold;
  bit        r_av, r_mv, r_iv;
  bit [3:0]  r_aa, r_ma, r_ia;
  bit [15:0] r_ad, r_md;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit av, input bit [3:0] aa, input bit [15:0] ad,
                               input bit mv, input bit [3:0] ma, input bit [15:0] md,
                               input bit iv, input bit [3:0] ia,
                               input bit [3:0] r1, input bit [3:0] r2);
    bus.alu_valid = av;
    bus.alu_addr  = aa;
    bus.alu_data  = ad;
    bus.mem_valid = mv;
    bus.mem_addr  = ma;
    bus.mem_data  = md;
    issue_valid   = iv;
    issue_addr    = ia;
    rs1_addr      = r1;
    rs2_addr      = r2;
  endtask

  task automatic commitModel(input bit [3:0] addr, input bit [15:0] data);
    if (addr == 4'hF) begin
      m_pc_we = 1'b1;
      m_pc_wd = data;
      m_we3   = 1'b0;
    end else begin
      m_we3  = 1'b1;
      m_a3   = addr;
      m_wd3  = data;
      m_pc_we = 1'b0;
      busy_m[addr] = 1'b0;
    end
  endtask

  task automatic resetModel();
    busy_m  = '0;
    losses  = 0;
    m_we3   = 1'b0;
    m_pc_we = 1'b0;
    m_a3    = '0;
    m_wd3   = '0;
    m_pc_wd = '0;
  endtask

  // One clock: check outputs for the currently driven inputs, then advance the model.
  task automatic runCycle();
    #1;
    exp_alu_rdy = !reset && bus.alu_valid && (!bus.mem_valid || losses == STARVE_MAX);
    exp_mem_rdy = !reset && bus.mem_valid && !exp_alu_rdy;
    checkOutput("alu_ready", bus.alu_ready, exp_alu_rdy);
    checkOutput("mem_ready", bus.mem_ready, exp_mem_rdy);
    checkOutput("hazard", hazard, busy_m[rs1_addr] | busy_m[rs2_addr]);
    checkOutput("we3", we3, m_we3 && !reset);
    checkOutput("pc_we", pc_we, m_pc_we && !reset);
    checkOutput("a3", a3, m_a3);
    checkOutput("wd3", wd3, m_wd3);
    checkOutput("pc_wd", pc_wd, m_pc_wd);
    @(posedge clk);
    if (reset) begin
      resetModel();
    end else begin
      m_we3   = 1'b0;
      m_pc_we = 1'b0;
      if (exp_alu_rdy) begin
        commitModel(bus.alu_addr, bus.alu_data);
        losses = 0;
      end else if (exp_mem_rdy) begin
        commitModel(bus.mem_addr, bus.mem_data);
        if (bus.alu_valid) losses++;
      end
      if (!bus.alu_valid) losses = 0;
      if (issue_valid && issue_addr != 4'hF) busy_m[issue_addr] = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetModel();

    // Reset values with requests pending: readys stay low
    applyStimulus(1, 4'd2, 16'h1111, 1, 4'd3, 16'h2222, 0, 0, 0, 0);
    runCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("rst_we3", we3, 0);
    checkOutput("rst_pc_we", pc_we, 0);
    checkOutput("rst_a3", a3, 0);
    checkOutput("rst_wd3", wd3, 0);
    checkOutput("rst_pc_wd", pc_wd, 0);
    for (int i = 0; i < 16; i++) begin
      rs1_addr = 4'(i);
      rs2_addr = 4'(15 - i);
      #0.1;
      checkOutput("rst_hazard", hazard, 0);
    end
    @(negedge clk);
    reset = 1'b0;

    // Single ALU write
    applyStimulus(1, 4'd3, 16'h1234, 0, 0, 0, 0, 0, 0, 0);
    runCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("alu_we3", we3, 1);
    checkOutput("alu_a3", a3, 3);
    checkOutput("alu_wd3", wd3, 16'h1234);
    checkOutput("alu_pc_we", pc_we, 0);
    runCycle();

    // Contention: mem,mem,mem,alu repeating
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 4'd2, 16'hAAAA, 1, 4'd6, 16'h5555, 0, 0, 0, 0);
      #1;
      checkOutput("contention_alu", bus.alu_ready, (i % 4) == 3);
      checkOutput("contention_mem", bus.mem_ready, (i % 4) != 3);
      runCycle();
    end

    // PC redirect leaves the busy set alone
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'd9, 0, 0);
    runCycle();
    applyStimulus(0, 0, 0, 1, 4'hF, 16'h00F0, 0, 0, 4'd9, 4'hF);
    runCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 4'd9, 4'hF);
    #1;
    checkOutput("pc_pc_we", pc_we, 1);
    checkOutput("pc_pc_wd", pc_wd, 16'h00F0);
    checkOutput("pc_we3", we3, 0);
    checkOutput("pc_busy_kept", hazard, 1);
    runCycle();
    applyStimulus(1, 4'd9, 16'h0909, 0, 0, 0, 0, 0, 0, 0);
    runCycle();

    // Scoreboard set, release, and same-cycle set/clear
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'd5, 4'd5, 0);
    runCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 4'd5, 0);
    #1;
    checkOutput("sb_issue_hazard", hazard, 1);
    runCycle();
    applyStimulus(1, 4'd5, 16'h0505, 0, 0, 0, 0, 0, 4'd5, 0);
    runCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 4'd5, 0);
    #1;
    checkOutput("sb_release", hazard, 0);
    runCycle();
    applyStimulus(1, 4'd5, 16'h5050, 0, 0, 0, 1, 4'd5, 0, 0);
    runCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd5);
    #1;
    checkOutput("sb_set_wins", hazard, 1);
    runCycle();
    applyStimulus(1, 4'd5, 16'h0055, 0, 0, 0, 0, 0, 0, 0);
    runCycle();

    // Reset mid-operation discards the write in flight
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'd8, 0, 0);
    runCycle();
    applyStimulus(1, 4'd4, 16'hBEEF, 0, 0, 0, 0, 0, 4'd8, 0);
    runCycle();
    reset = 1'b1;
    applyStimulus(1, 4'd7, 16'h7777, 1, 4'd1, 16'h1111, 0, 0, 4'd8, 0);
    #1;
    checkOutput("midrst_we3", we3, 0);
    checkOutput("midrst_alu_ready", bus.alu_ready, 0);
    checkOutput("midrst_mem_ready", bus.mem_ready, 0);
    runCycle();
    runCycle();
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 4'd8, 4'd4);
    #1;
    checkOutput("midrst_busy_clear", hazard, 0);
    checkOutput("midrst_we3_after", we3, 0);
    runCycle();

    // Random traffic honouring the hold-until-ready rule
    alu_hold = 1'b0;
    mem_hold = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!alu_hold) begin
        r_av = 1'($urandom_range(0, 1));
        r_aa = 4'($urandom_range(0, 15));
        r_ad = 16'($urandom);
      end
      if (!mem_hold) begin
        r_mv = 1'($urandom_range(0, 1));
        r_ma = 4'($urandom_range(0, 15));
        r_md = 16'($urandom);
      end
      r_iv = 1'($urandom_range(0, 1));
      r_ia = 4'($urandom_range(0, 15));
      reset = ($urandom_range(0, 63) == 0);
      applyStimulus(r_av, r_aa, r_ad, r_mv, r_ma, r_md, r_iv, r_ia,
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      runCycle();
      alu_hold = r_av && !exp_alu_rdy;
      mem_hold = r_mv && !exp_mem_rdy;
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
